vend_payout: RTL and testbench

VEND_PAYOUT -- requirements
Module: vend_payout

---
 rtl/vend_payout.sv | 143 ++++++++++++++
 tb/tb_vend_payout.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vend_payout.sv
// Vending payout controller: drives the dispense motor and confirms the drop,
// or ejects refund coins one solenoid run at a time. Moore outputs from state.
module vend_payout #(
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 16,
  parameter int KICK_CYCLES  = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dispense,
  input  logic       money_return,
  input  logic [1:0] refund_coins,
  input  logic       item_sense,
  output logic       motor_on,
  output logic       hopper_kick,
  output logic       busy,
  output logic       vend_done,
  output logic       return_done,
  output logic       fault,
  output logic [2:0] st
);

  localparam int MAXP_A = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int MAXP_B = (KICK_CYCLES > GAP_CYCLES) ? KICK_CYCLES : GAP_CYCLES;
  localparam int MAXP   = (MAXP_A > MAXP_B) ? MAXP_A : MAXP_B;
  localparam int CW     = $clog2(MAXP + 1);

  // Counter holds "cycles remaining after this one", so loads are N-1.
  localparam logic [CW-1:0] L_MOTOR = CW'(MOTOR_CYCLES - 1);
  localparam logic [CW-1:0] L_DROP  = CW'(DROP_TIMEOUT - 1);
  localparam logic [CW-1:0] L_KICK  = CW'(KICK_CYCLES - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOTOR  = 3'd1,
    S_WAIT   = 3'd2,
    S_KICK   = 3'd3,
    S_GAP    = 3'd4,
    S_DONE_V = 3'd5,
    S_DONE_R = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_coins;
  logic          r_seen;
  logic          r_held;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_coins <= '0;
      r_seen  <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_held <= 1'b0;
          if (dispense) begin
            r_state <= S_MOTOR;
            r_cnt   <= L_MOTOR;
            r_seen  <= 1'b0;
          end else if (money_return) begin
            r_state <= S_KICK;
            r_cnt   <= L_KICK;
            r_coins <= (refund_coins == 2'd0) ? 2'd1 : refund_coins;
          end
        end
        S_MOTOR: begin
          if (item_sense) r_seen <= 1'b1;
          if (r_cnt == '0) begin
            if (r_seen || item_sense) begin
              r_state <= S_DONE_V;
              r_cnt   <= '0;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= L_DROP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (item_sense) begin
            r_state <= S_DONE_V;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_state <= S_FAULT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_KICK: begin
          if (r_cnt == '0) begin
            r_coins <= r_coins - 1'b1;
            if (r_coins == 2'd1) begin
              r_state <= S_DONE_R;
              r_cnt   <= '0;
            end else begin
              r_state <= S_GAP;
              r_cnt   <= L_GAP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_KICK;
            r_cnt   <= L_KICK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE_V, S_DONE_R: begin
          // Hold here until both requests drop so a held level cannot re-trigger.
          r_held <= 1'b1;
          if (!dispense && !money_return) begin
            r_state <= S_IDLE;
            r_held  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign motor_on    = (r_state == S_MOTOR);
  assign hopper_kick = (r_state == S_KICK);
  assign busy        = (r_state != S_IDLE);
  assign vend_done   = (r_state == S_DONE_V) && !r_held;
  assign return_done = (r_state == S_DONE_R) && !r_held;
  assign fault       = (r_state == S_FAULT);
  assign st          = r_state;

endmodule

// File: tb/tb_vend_payout.sv
// Directed bench for vend_payout: vend, drop timeout/fault, refunds, priority, reset.
module tb_vend_payout;
  logic       clk = 1'b0;
  logic       rst, dispense, money_return, item_sense;
  logic [1:0] refund_coins;
  logic       motor_on, hopper_kick, busy, vend_done, return_done, fault;
  logic [2:0] st;

  int npass = 0;
  int ntot  = 0;
  int n_motor, n_kick, n_vd, n_rd, rd_at;
  logic [29:0] kick_trc, kick_exp;

  vend_payout dut (
    .clk(clk), .rst(rst), .dispense(dispense), .money_return(money_return),
    .refund_coins(refund_coins), .item_sense(item_sense),
    .motor_on(motor_on), .hopper_kick(hopper_kick), .busy(busy),
    .vend_done(vend_done), .return_done(return_done), .fault(fault), .st(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge; sample 1 time unit later. Drives must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("no_overlap", {31'd0, motor_on & hopper_kick}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; dispense = 1'b0; money_return = 1'b0; item_sense = 1'b0; refund_coins = 2'd0;
    tick(); tick();
    chk("rst_st", {29'd0, st}, 32'd0);
    chk("rst_outs", {26'd0, motor_on, hopper_kick, busy, vend_done, return_done, fault}, 32'd0);

    // Vend with item seen in motor cycle 3, dispense held throughout.
    rst = 1'b0; dispense = 1'b1;
    n_motor = 0; n_vd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_motor += motor_on;
      n_vd    += vend_done;
      if (i == 1) item_sense = 1'b1;
      if (i == 2) item_sense = 1'b0;
    end
    chk("vend_motor_cycles", n_motor, 32'd8);
    chk("vend_done_once", n_vd, 32'd1);
    chk("vend_hold_st", {29'd0, st}, 32'd5);
    chk("vend_hold_busy", {31'd0, busy}, 32'd1);
    dispense = 1'b0;
    tick();
    chk("vend_rearm_idle", {29'd0, st}, 32'd0);

    // Late drop: request dropped mid-motor must not abort; item 5 cycles after motor stops.
    dispense = 1'b1;
    tick();
    chk("late_motor", {31'd0, motor_on}, 32'd1);
    dispense = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("late_wait_st", {29'd0, st}, 32'd2);
    for (int i = 0; i < 4; i++) tick();
    item_sense = 1'b1;
    tick();
    chk("late_vend_done", {31'd0, vend_done}, 32'd1);
    chk("late_st", {29'd0, st}, 32'd5);
    item_sense = 1'b0;
    tick();
    chk("late_idle", {29'd0, st}, 32'd0);

    // Refund of 2 coins with money_return held: kick 4, gap 4, kick 4, return_done.
    money_return = 1'b1; refund_coins = 2'd2;
    n_rd = 0; rd_at = -1; n_motor = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      kick_trc[i] = hopper_kick;
      kick_exp[i] = (i < 4) || (i >= 8 && i < 12);
      n_rd    += return_done;
      n_motor += motor_on;
      if (return_done) rd_at = i;
    end
    chk("ref2_kick_pattern", {2'd0, kick_trc}, {2'd0, kick_exp});
    chk("ref2_done_once", n_rd, 32'd1);
    chk("ref2_done_at", rd_at, 32'd12);
    chk("ref2_no_motor", n_motor, 32'd0);
    chk("ref2_hold_st", {29'd0, st}, 32'd6);
    money_return = 1'b0;
    tick();
    chk("ref2_idle", {29'd0, st}, 32'd0);

    // Zero coins is treated as one.
    money_return = 1'b1; refund_coins = 2'd0;
    n_kick = 0; n_rd = 0; rd_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_kick += hopper_kick;
      n_rd   += return_done;
      if (return_done) rd_at = i;
    end
    chk("ref0_kicks", n_kick, 32'd4);
    chk("ref0_done_at", rd_at, 32'd4);
    chk("ref0_done_once", n_rd, 32'd1);
    money_return = 1'b0;
    tick();
    chk("ref0_idle", {29'd0, st}, 32'd0);

    // Both requests together: vend wins, no coins.
    dispense = 1'b1; money_return = 1'b1; refund_coins = 2'd1; item_sense = 1'b1;
    n_kick = 0; n_vd = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      n_kick += hopper_kick;
      n_vd   += vend_done;
    end
    chk("both_no_kick", n_kick, 32'd0);
    chk("both_vend_once", n_vd, 32'd1);
    dispense = 1'b0; money_return = 1'b0; item_sense = 1'b0;
    tick();
    chk("both_idle", {29'd0, st}, 32'd0);

    // Reset in the second KICK cycle.
    money_return = 1'b1; refund_coins = 2'd3;
    tick();
    chk("rk_kick1", {31'd0, hopper_kick}, 32'd1);
    tick();
    chk("rk_kick2", {31'd0, hopper_kick}, 32'd1);
    rst = 1'b1; money_return = 1'b0;
    tick();
    chk("rk_kick_off", {31'd0, hopper_kick}, 32'd0);
    chk("rk_st", {29'd0, st}, 32'd0);

    // Request accepted on first edge after reset release; no item -> fault after timeout.
    rst = 1'b0; dispense = 1'b1;
    tick();
    chk("first_req_motor", {29'd0, st}, 32'd1);
    dispense = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_motor_last", {31'd0, motor_on}, 32'd1);
    for (int i = 0; i < 16; i++) tick();
    chk("to_wait_last", {29'd0, st}, 32'd2);
    chk("to_no_fault_yet", {31'd0, fault}, 32'd0);
    tick();
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_fault_st", {29'd0, st}, 32'd7);
    dispense = 1'b1; money_return = 1'b1; refund_coins = 2'd1;
    n_motor = 0; n_kick = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_motor += motor_on;
      n_kick  += hopper_kick;
    end
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    chk("fault_drives_low", n_motor + n_kick, 32'd0);
    rst = 1'b1; dispense = 1'b0; money_return = 1'b0;
    tick();
    chk("fault_cleared", {28'd0, fault, st}, 32'd0);
    chk("fault_busy_off", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
